// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential signed divider.
package divider_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Q,
        CHECK,
        ITER,
        FIX,
        OUT_Q,
        OUT_R
    } div_state_t;

    // Magnitude of a sign-extended operand; callers truncate to their width.
    function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
        return v[31] ? unsigned'(-v) : unsigned'(v);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract |M|, set quotient bit.
module div_restore_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] ext;
    logic             take;

    always_comb begin
        ext    = {a, q[WIDTH-1]};
        take   = (ext >= (WIDTH+2)'(m));
        a_next = take ? (WIDTH+1)'(ext - (WIDTH+2)'(m)) : ext[WIDTH:0];
        q_next = {q[WIDTH-2:0], take};
    end

endmodule

// File: rtl/booth_divider_top.sv
// Sequential signed divider on the shared 8-bit operand/result bus protocol.
// Optional div0 flag port enabled by defining DIVIDER_DIV0_FLAG_EN.
module booth_divider_top
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] inbus,
    output logic             done,
    output logic [WIDTH-1:0] outbus
`ifdef DIVIDER_DIV0_FLAG_EN
    ,
    output logic             div0
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state, state_next;
    logic [WIDTH-1:0] m_reg, q_reg, quo, rem;
    logic [WIDTH:0]   a_reg;
    logic [CNT_W-1:0] cnt;
    logic             sign_q, sign_r;
    logic [WIDTH:0]   a_step_c;
    logic [WIDTH-1:0] q_step_c;
    logic [WIDTH-1:0] outbus_c;
    logic             done_c;
`ifdef DIVIDER_DIV0_FLAG_EN
    logic             m_zero;
    logic             div0_c;
`endif

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .m      (m_reg),
        .a_next (a_step_c),
        .q_next (q_step_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = LOAD_Q;
            LOAD_Q:  state_next = CHECK;
            CHECK:   state_next = (m_reg == '0) ? OUT_Q : ITER;
            ITER:    if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = OUT_Q;
            OUT_Q:   state_next = OUT_R;
            OUT_R:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; registered below so results appear one cycle after the state
    always_comb begin
        outbus_c = '0;
        done_c   = 1'b0;
        case (state)
            OUT_Q: outbus_c = quo;
            OUT_R: begin
                outbus_c = rem;
                done_c   = 1'b1;
            end
            default: ;
        endcase
`ifdef DIVIDER_DIV0_FLAG_EN
        div0_c = m_zero && ((state == OUT_Q) || (state == OUT_R));
`endif
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg  <= '0;
            q_reg  <= '0;
            a_reg  <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            quo    <= '0;
            rem    <= '0;
            outbus <= '0;
            done   <= 1'b0;
`ifdef DIVIDER_DIV0_FLAG_EN
            m_zero <= 1'b0;
            div0   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:   if (enable) m_reg <= inbus;
                LOAD_Q: q_reg <= inbus;
                CHECK: begin
`ifdef DIVIDER_DIV0_FLAG_EN
                    m_zero <= (m_reg == '0);
`endif
                    if (m_reg == '0) begin
                        quo <= '1;
                        rem <= q_reg;
                    end else begin
                        sign_q <= q_reg[WIDTH-1] ^ m_reg[WIDTH-1];
                        sign_r <= q_reg[WIDTH-1];
                        q_reg  <= WIDTH'(abs_mag(32'($signed(q_reg))));
                        m_reg  <= WIDTH'(abs_mag(32'($signed(m_reg))));
                        a_reg  <= '0;
                        cnt    <= '0;
                    end
                end
                ITER: begin
                    a_reg <= a_step_c;
                    q_reg <= q_step_c;
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    quo <= sign_q ? WIDTH'(-q_reg) : q_reg;
                    rem <= sign_r ? WIDTH'(-a_reg[WIDTH-1:0]) : a_reg[WIDTH-1:0];
                end
                default: ;
            endcase
            outbus <= outbus_c;
            done   <= done_c;
`ifdef DIVIDER_DIV0_FLAG_EN
            div0   <= div0_c;
`endif
        end
    end

endmodule

// File: tb/tb_booth_divider_top.sv
// Scoreboard bench for booth_divider_top: randomized operands against a plain-arithmetic model.
module tb_booth_divider_top;
    import divider_pkg::*;

    localparam int unsigned W = 8;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] inbus  = '0;
    logic         done;
    logic [W-1:0] outbus;
`ifdef DIVIDER_DIV0_FLAG_EN
    logic         div0;
`endif

    booth_divider_top #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .inbus  (inbus),
        .done   (done),
        .outbus (outbus)
`ifdef DIVIDER_DIV0_FLAG_EN
        ,
        .div0   (div0)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  start;
        int unsigned  lat;
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         zero;
    } exp_t;

    exp_t        sb[$];
    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: compares bus outputs against the head of the scoreboard each cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() != 0 && edge_cnt == sb[0].start + sb[0].lat) begin
                check("quotient", 32'(outbus), 32'(sb[0].quo));
                check("done_in_q", 32'(done), 32'd0);
`ifdef DIVIDER_DIV0_FLAG_EN
                check("div0_in_q", 32'(div0), 32'(sb[0].zero));
`endif
            end else if (sb.size() != 0 && edge_cnt == sb[0].start + sb[0].lat + 1) begin
                check("remainder", 32'(outbus), 32'(sb[0].rem));
                check("done_in_r", 32'(done), 32'd1);
`ifdef DIVIDER_DIV0_FLAG_EN
                check("div0_in_r", 32'(div0), 32'(sb[0].zero));
`endif
                void'(sb.pop_front());
            end else begin
                check("idle_outbus", 32'(outbus), 32'd0);
                check("idle_done", 32'(done), 32'd0);
`ifdef DIVIDER_DIV0_FLAG_EN
                check("idle_div0", 32'(div0), 32'd0);
`endif
            end
        end
    end

    function automatic logic drive_en(input int mode);
        if (mode == 2) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // Reference: signed division truncating toward zero; divisor 0 gives all ones / dividend
    task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q, input int mode, output exp_t e);
        int n, d;
        @(negedge clk);
        enable  = 1'b1;
        inbus   = m;
        e.start = edge_cnt + 1;
        e.zero  = (m == '0);
        e.lat   = e.zero ? 3 : W + 4;
        if (e.zero) begin
            e.quo = '1;
            e.rem = q;
        end else begin
            n     = int'($signed(q));
            d     = int'($signed(m));
            e.quo = W'(n / d);
            e.rem = W'(n % d);
        end
        sb.push_back(e);
        @(negedge clk);
        inbus  = q;
        enable = drive_en(mode);
    endtask

    task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input int mode);
        exp_t e;
        start_op(m, q, mode, e);
        repeat (e.lat) begin
            @(negedge clk);
            inbus  = W'($urandom);
            enable = drive_en(mode);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enable = 1'b0;
            inbus  = W'($urandom);
        end
    endtask

    // Assert reset a little after the given edge of an in-flight operation
    task automatic reset_at(input int unsigned target, input logic [31:0] pre_state);
        do begin
            @(posedge clk);
            #2;
        end while (edge_cnt < target);
        check("pre_reset_state", 32'(dut.state), pre_state);
        rst_n = 1'b0;
        #1;
        check("rst_outbus", 32'(outbus), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] m, q;
        #1;
        check("reset_outbus", 32'(outbus), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Directed vectors from the signed-division corner cases
        do_op(8'h07, 8'h64, 0); idle(1);
        do_op(8'h07, 8'h9C, 0); idle(1);
        do_op(8'hF9, 8'h64, 0); idle(1);
        do_op(8'hF9, 8'h9C, 0); idle(1);
        do_op(8'h00, 8'h25, 0); idle(1);
        do_op(8'hFF, 8'h80, 0); idle(1);
        do_op(8'h09, 8'h05, 0); idle(1);
        do_op(8'h80, 8'h80, 0); idle(1);
        do_op(8'h01, 8'h7F, 0); idle(1);

        // Enable toggling mid-operation, then back-to-back with enable held high
        do_op(8'h0D, 8'hB5, 1); idle(2);
        do_op(8'h03, 8'h2A, 2);
        do_op(8'hFD, 8'hD6, 2);
        do_op(8'h00, 8'h81, 2); idle(2);

        // Reset during the sixth iteration, then during the remainder cycle
        start_op(8'h07, 8'h64, 0, e);
        reset_at(e.start + 8, 32'(ITER));
        idle(2);
        start_op(8'h05, 8'hE2, 0, e);
        reset_at(e.start + 13, 32'(IDLE));
        idle(2);
        do_op(8'h07, 8'h64, 0); idle(1);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            m = W'($urandom);
            q = W'($urandom);
            if ($urandom_range(0, 7) == 0) m = '0;
            if ($urandom_range(0, 7) == 0) q = 8'h80;
            if ($urandom_range(0, 9) == 0) m = 8'hFF;
            do_op(m, q, int'($urandom_range(0, 2)));
            idle(int'($urandom_range(0, 2)));
        end

        idle(1);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
